// File: rtl/eth_tx_mac_param.sv
// eth_tx_mac_param: byte stream to RMII/MII transmit MAC (preamble, pad, FCS, gap, abort); define ETH_TX_STATS_EN for frame counters
module eth_tx_mac_param #(
  parameter int PHY_W          = 2,
  parameter int PREAMBLE_BYTES = 7,
  parameter int MIN_FRAME      = 60,
  parameter int MAX_FRAME      = 1514,
  parameter int IFG_BYTES      = 12
) (
  input  logic             clk_mac,
  input  logic             rst_n,
  input  logic             speed_10,
  input  logic             tx_vld,
  input  logic [7:0]       tx_dat,
  input  logic             tx_sof,
  input  logic             tx_eof,
  input  logic             tx_err,
  output logic             tx_ack,
  output logic             tx_busy,
  output logic             eth_txen,
  output logic [PHY_W-1:0] eth_txd,
  output logic [15:0]      stat_ok,
  output logic [15:0]      stat_err
);
  localparam int S = 8 / PHY_W;
  localparam logic [2:0] IDLE = 3'd0, PREAMBLE = 3'd1, BODY = 3'd2, PAD = 3'd3, FCS = 3'd4, GAP = 3'd5;
  logic [2:0]  state;
  logic        spd, cur_en, inv, tick, stb, take;
  logic [3:0]  div;
  logic [1:0]  sym;
  logic [7:0]  sh, idx, fcs_b;
  logic [10:0] cnt, cnt_inc;
  logic [31:0] crc, fcs;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
    return r;
  endfunction

  assign tick    = !spd || div == 4'd9;
  assign stb     = tick && sym == 2'(S - 1);
  assign take    = tx_vld && !tx_err && cnt != 11'(MAX_FRAME);
  assign cnt_inc = cnt + {10'd0, ~&cnt};
  // FCS laid out so that the first byte on the wire is fcs[31:24]
  assign fcs     = ~{crc[7:0], crc[15:8], crc[23:16], crc[31:24]};
  assign fcs_b   = (idx[1:0] == 2'd0 ? fcs[31:24] : idx[1:0] == 2'd1 ? fcs[23:16] :
                    idx[1:0] == 2'd2 ? fcs[15:8] : fcs[7:0]) ^ {8{inv}};
  assign tx_ack  = rst_n && ((state == IDLE && tx_vld && !tx_sof) ||
                             (state == BODY && stb && (tx_vld || tx_err)));
  assign tx_busy = state != IDLE;

  // symbol timing: speed latched while idle, divider and symbol index restart each frame
  always_ff @(posedge clk_mac)
    if (!rst_n) begin
      spd <= 1'b0;
      div <= '0;
      sym <= '0;
    end else if (state == IDLE) begin
      spd <= speed_10;
      div <= '0;
      sym <= '0;
    end else begin
      div <= tick ? 4'd0 : div + 4'd1;
      if (tick) sym <= stb ? 2'd0 : sym + 2'd1;
    end

  // registered PHY pins, advanced once per symbol tick
  always_ff @(posedge clk_mac)
    if (!rst_n) begin
      eth_txen <= 1'b0;
      eth_txd  <= '0;
    end else if (tick && state != IDLE) begin
      eth_txen <= cur_en;
      eth_txd  <= sh[PHY_W-1:0];
    end

  // frame sequencer: each byte strobe loads the byte for the next byte time
  always_ff @(posedge clk_mac)
    if (!rst_n) begin
      state  <= IDLE;
      sh     <= '0;
      cur_en <= 1'b0;
      idx    <= '0;
      cnt    <= '0;
      crc    <= '1;
      inv    <= 1'b0;
    end else begin
      if (tick) sh <= sh >> PHY_W;
      case (state)
        IDLE: begin
          crc <= '1;
          if (tx_vld && tx_sof) begin
            state  <= PREAMBLE;
            sh     <= 8'h55;
            cur_en <= 1'b1;
            idx    <= 8'd1;
            cnt    <= '0;
            inv    <= 1'b0;
          end
        end
        PREAMBLE: if (stb) begin
          sh  <= idx == 8'(PREAMBLE_BYTES) ? 8'hD5 : 8'h55;
          idx <= idx == 8'(PREAMBLE_BYTES) ? 8'd0 : idx + 8'd1;
          if (idx == 8'(PREAMBLE_BYTES)) state <= BODY;
        end
        BODY: if (stb) begin
          if (take) begin
            sh  <= tx_dat;
            crc <= crc_byte(crc, tx_dat);
            cnt <= cnt_inc;
            if (tx_eof) state <= cnt_inc < 11'(MIN_FRAME) ? PAD : FCS;
          end else begin
            sh    <= ~fcs[31:24];
            inv   <= 1'b1;
            idx   <= 8'd1;
            state <= FCS;
          end
        end
        PAD: if (stb) begin
          sh  <= 8'h00;
          crc <= crc_byte(crc, 8'h00);
          cnt <= cnt_inc;
          if (cnt_inc == 11'(MIN_FRAME)) state <= FCS;
        end
        FCS: if (stb) begin
          sh  <= fcs_b;
          idx <= idx == 8'd3 ? 8'd0 : idx + 8'd1;
          if (idx == 8'd3) state <= GAP;
        end
        GAP: if (tick) begin
          if (idx == 8'(IFG_BYTES + 1)) begin
            state <= IDLE;
            idx   <= '0;
          end else if (stb) begin
            sh     <= '0;
            cur_en <= 1'b0;
            idx    <= idx + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end

`ifdef ETH_TX_STATS_EN
  // count each frame as it enters the gap, split by abort status
  always_ff @(posedge clk_mac)
    if (!rst_n) begin
      stat_ok  <= '0;
      stat_err <= '0;
    end else if (state == FCS && stb && idx == 8'd3) begin
      stat_ok  <= stat_ok + {15'd0, !inv};
      stat_err <= stat_err + {15'd0, inv};
    end
`else
  assign stat_ok  = '0;
  assign stat_err = '0;
`endif
endmodule
